// File: rtl/vending_sequencer_fsm.sv
// Vending machine control FSM: owns the credit balance, sequences
// coin accept -> dispense -> change return, and runs the inactivity timer.
module vending_sequencer_fsm #(
   parameter int TOTAL_BITS = 31,
   parameter int WAIT_TIME  = 100,
   parameter int COIN_V0    = 100,
   parameter int COIN_V1    = 500,
   parameter int COIN_V2    = 1000,
   parameter int PRICE_0    = 400,
   parameter int PRICE_1    = 500,
   parameter int PRICE_2    = 1000,
   parameter int PRICE_3    = 2000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            i_input_coin,
   input  logic [3:0]            i_select_item,
   input  logic                  i_trigger_return,
   output logic [3:0]            o_available_item,
   output logic [3:0]            o_output_item,
   output logic [2:0]            o_return_coin,
   output logic [TOTAL_BITS-1:0] o_balance,
   output logic [31:0]           o_wait_time,
   output logic [1:0]            o_state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCEPT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   localparam logic [TOTAL_BITS-1:0] C_V0   = TOTAL_BITS'(COIN_V0);
   localparam logic [TOTAL_BITS-1:0] C_V1   = TOTAL_BITS'(COIN_V1);
   localparam logic [TOTAL_BITS-1:0] C_V2   = TOTAL_BITS'(COIN_V2);
   localparam logic [TOTAL_BITS-1:0] C_P0   = TOTAL_BITS'(PRICE_0);
   localparam logic [TOTAL_BITS-1:0] C_P1   = TOTAL_BITS'(PRICE_1);
   localparam logic [TOTAL_BITS-1:0] C_P2   = TOTAL_BITS'(PRICE_2);
   localparam logic [TOTAL_BITS-1:0] C_P3   = TOTAL_BITS'(PRICE_3);
   localparam logic [31:0]           C_WAIT = 32'(WAIT_TIME);

   state_t                r_state;
   logic [TOTAL_BITS-1:0] r_balance;
   logic [31:0]           r_wait;
   logic [3:0]            r_output_item;
   logic [2:0]            r_return_coin;

   logic                  w_coin_valid;
   logic                  w_coin_fits;
   logic                  w_sel_valid;
   logic                  w_sel_ok;
   logic [TOTAL_BITS-1:0] w_coin_value;
   logic [TOTAL_BITS-1:0] w_price;
   logic [TOTAL_BITS:0]   w_sum;
   logic [3:0]            w_available;
   logic [2:0]            w_change_coin;
   logic [TOTAL_BITS-1:0] w_change_value;

   always_comb begin
      w_coin_valid = $onehot(i_input_coin);
      case (i_input_coin)
         3'b001:  w_coin_value = C_V0;
         3'b010:  w_coin_value = C_V1;
         3'b100:  w_coin_value = C_V2;
         default: w_coin_value = '0;
      endcase
      // Carry out of the extra bit means the coin would overflow the balance.
      w_sum       = {1'b0, r_balance} + {1'b0, w_coin_value};
      w_coin_fits = ~w_sum[TOTAL_BITS];
   end

   always_comb begin
      w_available[0] = (r_state == ST_ACCEPT) && (r_balance >= C_P0);
      w_available[1] = (r_state == ST_ACCEPT) && (r_balance >= C_P1);
      w_available[2] = (r_state == ST_ACCEPT) && (r_balance >= C_P2);
      w_available[3] = (r_state == ST_ACCEPT) && (r_balance >= C_P3);
      w_sel_valid    = $onehot(i_select_item);
      w_sel_ok       = w_sel_valid && (|(i_select_item & w_available));
      case (i_select_item)
         4'b0001: w_price = C_P0;
         4'b0010: w_price = C_P1;
         4'b0100: w_price = C_P2;
         4'b1000: w_price = C_P3;
         default: w_price = '0;
      endcase
   end

   // Greedy change: largest coin that still fits in the remaining balance.
   always_comb begin
      if (r_balance >= C_V2) begin
         w_change_coin  = 3'b100;
         w_change_value = C_V2;
      end else if (r_balance >= C_V1) begin
         w_change_coin  = 3'b010;
         w_change_value = C_V1;
      end else if (r_balance >= C_V0) begin
         w_change_coin  = 3'b001;
         w_change_value = C_V0;
      end else begin
         w_change_coin  = 3'b000;
         w_change_value = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_balance     <= '0;
         r_wait        <= C_WAIT;
         r_output_item <= '0;
         r_return_coin <= '0;
      end else begin
         r_output_item <= '0;
         r_return_coin <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_coin_valid) begin
                  if (w_coin_fits) r_balance <= w_sum[TOTAL_BITS-1:0];
                  r_wait  <= C_WAIT;
                  r_state <= ST_ACCEPT;
               end
            end
            ST_ACCEPT: begin
               if (w_coin_valid) begin
                  if (w_coin_fits) r_balance <= w_sum[TOTAL_BITS-1:0];
                  r_wait <= C_WAIT;
               end else if (i_trigger_return) begin
                  r_state <= ST_CHANGE;
               end else if (w_sel_ok) begin
                  r_balance     <= r_balance - w_price;
                  r_output_item <= i_select_item;
                  r_wait        <= C_WAIT;
                  r_state       <= ST_DISPENSE;
               end else if (r_wait == 32'd0) begin
                  r_state <= ST_CHANGE;
               end else begin
                  r_wait <= r_wait - 32'd1;
               end
            end
            ST_DISPENSE: begin
               r_state <= (r_balance != '0) ? ST_ACCEPT : ST_IDLE;
            end
            ST_CHANGE: begin
               if (w_change_coin != 3'b000) begin
                  r_return_coin <= w_change_coin;
                  r_balance     <= r_balance - w_change_value;
               end else begin
                  r_balance <= '0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_available_item = w_available;
   assign o_output_item    = r_output_item;
   assign o_return_coin    = r_return_coin;
   assign o_balance        = r_balance;
   assign o_wait_time      = r_wait;
   assign o_state          = r_state;

endmodule

// File: tb/tb_vending_sequencer_fsm.sv
// Bench for vending_sequencer_fsm: directed scenarios plus randomized traffic
// checked against a transaction-level model of credit, timer and change.
module tb_vending_sequencer_fsm;

   localparam int TB   = 12;
   localparam int WT   = 5;
   localparam int MAXB = (1 << TB) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    i_input_coin = '0;
   logic [3:0]    i_select_item = '0;
   logic          i_trigger_return = 1'b0;
   logic [3:0]    o_available_item;
   logic [3:0]    o_output_item;
   logic [2:0]    o_return_coin;
   logic [TB-1:0] o_balance;
   logic [31:0]   o_wait_time;
   logic [1:0]    o_state;

   always #5 clk = ~clk;

   vending_sequencer_fsm #(.TOTAL_BITS(TB), .WAIT_TIME(WT)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_balance        (o_balance),
      .o_wait_time      (o_wait_time),
      .o_state          (o_state)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 accept, 2 dispense, 3 change.
   int         m_st = 0;
   int         m_bal = 0;
   int         m_wait = WT;
   logic [3:0] m_out = '0;
   logic [2:0] m_ret = '0;
   int         chg_q[$];
   logic [2:0] exp_q[$];

   function automatic int coin_val(input logic [2:0] c);
      case (c)
         3'b001:  return 100;
         3'b010:  return 500;
         3'b100:  return 1000;
         default: return 0;
      endcase
   endfunction

   function automatic int price_of(input int i);
      case (i)
         0:       return 400;
         1:       return 500;
         2:       return 1000;
         default: return 2000;
      endcase
   endfunction

   function automatic logic [2:0] coin_code(input int v);
      if (v == 1000) return 3'b100;
      if (v == 500)  return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [3:0] exp_avail();
      logic [3:0] a;
      a = '0;
      if (m_st == 1)
         for (int i = 0; i < 4; i++) a[i] = (m_bal >= price_of(i));
      return a;
   endfunction

   // Whole change payout is planned up front as a list of coins.
   task automatic plan_change();
      int rest;
      int vals[3];
      vals = '{1000, 500, 100};
      chg_q.delete();
      rest = m_bal;
      for (int k = 0; k < 3; k++)
         while (rest >= vals[k]) begin
            chg_q.push_back(vals[k]);
            rest -= vals[k];
         end
   endtask

   task automatic model_step(input logic [2:0] c, input logic [3:0] s,
                             input logic r, input logic rst);
      int cv;
      int idx;
      m_out = '0;
      m_ret = '0;
      if (rst) begin
         m_st = 0; m_bal = 0; m_wait = WT; chg_q.delete();
         return;
      end
      cv = ($countones(c) == 1) ? coin_val(c) : 0;
      idx = 0;
      for (int i = 0; i < 4; i++) if (s[i]) idx = i;
      case (m_st)
         0: if (cv > 0) begin
               if (m_bal + cv <= MAXB) m_bal += cv;
               m_wait = WT; m_st = 1;
            end
         1: if (cv > 0) begin
               if (m_bal + cv <= MAXB) m_bal += cv;
               m_wait = WT;
            end else if (r) begin
               m_st = 3; plan_change();
            end else if ($countones(s) == 1 && m_bal >= price_of(idx)) begin
               m_bal -= price_of(idx); m_out = s; m_wait = WT; m_st = 2;
            end else if (m_wait == 0) begin
               m_st = 3; plan_change();
            end else begin
               m_wait -= 1;
            end
         2: m_st = (m_bal != 0) ? 1 : 0;
         default: if (chg_q.size() > 0) begin
               cv = chg_q.pop_front();
               m_bal -= cv; m_ret = coin_code(cv);
            end else begin
               m_bal = 0; m_st = 0;
            end
      endcase
   endtask

   task automatic step(input logic [2:0] c, input logic [3:0] s,
                       input logic r, input logic rst);
      i_input_coin = c; i_select_item = s; i_trigger_return = r; reset = rst;
      @(posedge clk);
      model_step(c, s, r, rst);
      #1;
      i_input_coin = '0; i_select_item = '0; i_trigger_return = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      step(3'b100, 4'b0001, 1'b1, 1'b1);
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", o_state); end
      checks++; if (o_balance !== '0) begin errors++; $display("FAIL reset_balance got %0d want 0", o_balance); end
      checks++; if (o_wait_time !== 32'(WT)) begin errors++; $display("FAIL reset_wait got %0d want %0d", o_wait_time, WT); end
      checks++; if (o_output_item !== 4'b0) begin errors++; $display("FAIL reset_item got %b want 0000", o_output_item); end
      checks++; if (o_return_coin !== 3'b0) begin errors++; $display("FAIL reset_coin got %b want 000", o_return_coin); end
      checks++; if (o_available_item !== 4'b0) begin errors++; $display("FAIL reset_avail got %b want 0000", o_available_item); end
   endtask

   task automatic test_coin_accept();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      step(3'b100, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_balance !== 12'd1000) begin errors++; $display("FAIL t1_balance got %0d want 1000", o_balance); end
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL t1_state got %0d want 1", o_state); end
      checks++; if (o_available_item !== 4'b0111) begin errors++; $display("FAIL t1_avail got %b want 0111", o_available_item); end
   endtask

   task automatic test_dispense();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      step(3'b010, 4'b0000, 1'b0, 1'b0);
      step(3'b010, 4'b0000, 1'b0, 1'b0);
      step(3'b000, 4'b0010, 1'b0, 1'b0);
      checks++; if (o_output_item !== 4'b0010) begin errors++; $display("FAIL t2_item got %b want 0010", o_output_item); end
      checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL t2_state got %0d want 2", o_state); end
      checks++; if (o_balance !== 12'd500) begin errors++; $display("FAIL t2_balance got %0d want 500", o_balance); end
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_state !== 2'd1 || o_output_item !== 4'b0) begin errors++; $display("FAIL t2_back_accept got st=%0d item=%b want st=1 item=0000", o_state, o_output_item); end
      step(3'b000, 4'b0010, 1'b0, 1'b0);
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_state !== 2'd0 || o_balance !== '0) begin errors++; $display("FAIL t2_idle got st=%0d bal=%0d want st=0 bal=0", o_state, o_balance); end
   endtask

   task automatic test_change();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      step(3'b100, 4'b0000, 1'b0, 1'b0);
      step(3'b010, 4'b0000, 1'b0, 1'b0);
      step(3'b001, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_balance !== 12'd1600) begin errors++; $display("FAIL t3_balance got %0d want 1600", o_balance); end
      step(3'b000, 4'b0000, 1'b1, 1'b0);
      checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL t3_state got %0d want 3", o_state); end
      exp_q.push_back(3'b100); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
      while (exp_q.size() > 0) begin
         logic [2:0] e;
         e = exp_q.pop_front();
         step(3'b001, 4'b0001, 1'b1, 1'b0);
         checks++; if (o_return_coin !== e) begin errors++; $display("FAIL t3_coin got %b want %b", o_return_coin, e); end
      end
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_return_coin !== 3'b0 || o_state !== 2'd0 || o_balance !== '0) begin errors++; $display("FAIL t3_done got coin=%b st=%0d bal=%0d want 000/0/0", o_return_coin, o_state, o_balance); end
   endtask

   task automatic test_timeout();
      int n;
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      step(3'b001, 4'b0000, 1'b0, 1'b0);
      n = 0;
      while (o_state !== 2'd3 && n < 20) begin
         step(3'b000, 4'b0000, 1'b0, 1'b0);
         n++;
      end
      checks++; if (n != 6) begin errors++; $display("FAIL t4_cycles got %0d want 6", n); end
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_return_coin !== 3'b001) begin errors++; $display("FAIL t4_coin got %b want 001", o_return_coin); end
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_state !== 2'd0 || o_return_coin !== 3'b0) begin errors++; $display("FAIL t4_idle got st=%0d coin=%b want 0/000", o_state, o_return_coin); end
   endtask

   task automatic test_invalid();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(3'b001, 4'b0000, 1'b0, 1'b0);
      step(3'b011, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_balance !== 12'd400) begin errors++; $display("FAIL t5_badcoin got %0d want 400", o_balance); end
      step(3'b001, 4'b0001, 1'b0, 1'b0);
      checks++; if (o_balance !== 12'd500 || o_output_item !== 4'b0) begin errors++; $display("FAIL t5_coin_prio got bal=%0d item=%b want 500/0000", o_balance, o_output_item); end
      step(3'b000, 4'b1000, 1'b0, 1'b0);
      checks++; if (o_output_item !== 4'b0 || o_state !== 2'd1) begin errors++; $display("FAIL t5_unafford got item=%b st=%0d want 0000/1", o_output_item, o_state); end
      step(3'b000, 4'b0011, 1'b0, 1'b0);
      checks++; if (o_output_item !== 4'b0 || o_balance !== 12'd500) begin errors++; $display("FAIL t5_multi got item=%b bal=%0d want 0000/500", o_output_item, o_balance); end
      checks++; if (o_wait_time !== 32'd3) begin errors++; $display("FAIL t5_wait got %0d want 3", o_wait_time); end
   endtask

   task automatic test_reset_mid_change();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      step(3'b100, 4'b0000, 1'b0, 1'b0);
      step(3'b010, 4'b0000, 1'b0, 1'b0);
      step(3'b001, 4'b0000, 1'b0, 1'b0);
      step(3'b000, 4'b0000, 1'b1, 1'b0);
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      checks++; if (o_state !== 2'd0 || o_balance !== '0) begin errors++; $display("FAIL t6_state got st=%0d bal=%0d want 0/0", o_state, o_balance); end
      checks++; if (o_return_coin !== 3'b0 || o_wait_time !== 32'(WT)) begin errors++; $display("FAIL t6_outputs got coin=%b wait=%0d want 000/%0d", o_return_coin, o_wait_time, WT); end
   endtask

   task automatic test_overflow();
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(3'b100, 4'b0000, 1'b0, 1'b0);
      step(3'b000, 4'b0000, 1'b0, 1'b0);
      step(3'b100, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_balance !== 12'd4000) begin errors++; $display("FAIL ovf_balance got %0d want 4000", o_balance); end
      checks++; if (o_wait_time !== 32'(WT)) begin errors++; $display("FAIL ovf_reload got %0d want %0d", o_wait_time, WT); end
      step(3'b001, 4'b0000, 1'b0, 1'b0);
      checks++; if (o_balance !== 12'd4000 || o_available_item !== 4'b1111) begin errors++; $display("FAIL ovf_small got bal=%0d avail=%b want 4000/1111", o_balance, o_available_item); end
   endtask

   task automatic test_random();
      logic [2:0] c;
      logic [3:0] s;
      logic       r, rst;
      int         p;
      step(3'b000, 4'b0000, 1'b0, 1'b1);
      for (int n = 0; n < 600; n++) begin
         p = $urandom_range(0, 99);
         if (p < 30)      c = 3'(1 << $urandom_range(0, 2));
         else if (p < 36) c = 3'($urandom_range(0, 7));
         else             c = 3'b000;
         if ($urandom_range(0, 1) == 1) s = 4'(1 << $urandom_range(0, 3));
         else                           s = 4'($urandom_range(0, 15));
         r   = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step(c, s, r, rst);
         checks++; if (o_state !== 2'(m_st)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", n, o_state, m_st); end
         checks++; if (o_balance !== TB'(m_bal)) begin errors++; $display("FAIL rnd_balance cyc %0d got %0d want %0d", n, o_balance, m_bal); end
         checks++; if (o_wait_time !== 32'(m_wait)) begin errors++; $display("FAIL rnd_wait cyc %0d got %0d want %0d", n, o_wait_time, m_wait); end
         checks++; if (o_output_item !== m_out) begin errors++; $display("FAIL rnd_item cyc %0d got %b want %b", n, o_output_item, m_out); end
         checks++; if (o_return_coin !== m_ret) begin errors++; $display("FAIL rnd_coin cyc %0d got %b want %b", n, o_return_coin, m_ret); end
         checks++; if (o_available_item !== exp_avail()) begin errors++; $display("FAIL rnd_avail cyc %0d got %b want %b", n, o_available_item, exp_avail()); end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_coin_accept();
      test_dispense();
      test_change();
      test_timeout();
      test_invalid();
      test_reset_mid_change();
      test_overflow();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
